// File: rtl/sort_pkg.sv
// Shared types and sizing for the selection-sort engine: loader, datapath and controller.
package sort_pkg;

    localparam int W       = 8;
    localparam int N_WORDS = 8;
    localparam int AW      = $clog2(N_WORDS);

    typedef logic [W-1:0]  word_t;
    typedef logic [AW-1:0] addr_t;

    typedef enum logic [2:0] {
        LOAD,
        DRAIN,
        FLUSH,
        START,
        WAIT
    } loader_state_e;

endpackage

// File: rtl/sort_loader.sv
// Stream front end: preloads one frame into the sort RAM, launches the sort,
// flags malformed frames and records per-frame sort latency.
module sort_loader #(
    parameter int W       = sort_pkg::W,
    parameter int N_WORDS = sort_pkg::N_WORDS,
    parameter int AW      = sort_pkg::AW,
    parameter int CW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [W-1:0]  in_data,
    input  logic          in_last,
    output logic          in_ready,
    output logic          init_mode,
    output logic [AW-1:0] init_addr,
    output logic [W-1:0]  init_data,
    output logic          sort_start,
    input  logic          sort_done,
    output logic          frame_done,
    output logic          err_short,
    output logic          err_long,
    output logic [CW-1:0] sort_cycles
);
    import sort_pkg::*;

    localparam logic [AW-1:0] LAST_ADDR = AW'(N_WORDS - 1);
    localparam logic [CW-1:0] LAT_MAX   = '1;

    loader_state_e state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] lat_q, lat_d, lat_inc;
    logic [CW-1:0] cycles_d;
    logic          accept;
    logic          wr_d, short_d, long_d, done_d;

    assign accept  = in_valid && in_ready;
    assign lat_inc = (lat_q == LAT_MAX) ? lat_q : lat_q + CW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= LOAD;
            cnt_q       <= '0;
            lat_q       <= '0;
            sort_cycles <= '0;
            init_mode   <= 1'b0;
            init_addr   <= '0;
            init_data   <= '0;
            err_short   <= 1'b0;
            err_long    <= 1'b0;
            frame_done  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lat_q       <= lat_d;
            sort_cycles <= cycles_d;
            init_mode   <= wr_d;
            err_short   <= short_d;
            err_long    <= long_d;
            frame_done  <= done_d;
            if (wr_d) begin
                init_addr <= cnt_q;
                init_data <= in_data;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_d      = lat_q;
        cycles_d   = sort_cycles;
        wr_d       = 1'b0;
        short_d    = 1'b0;
        long_d     = 1'b0;
        done_d     = 1'b0;
        in_ready   = 1'b0;
        sort_start = 1'b0;

        unique case (state_q)
            LOAD: begin
                in_ready = 1'b1;
                if (accept) begin
                    wr_d = 1'b1;
                    if (cnt_q == LAST_ADDR) begin
                        cnt_d   = '0;
                        long_d  = !in_last;
                        state_d = in_last ? FLUSH : DRAIN;
                    end else if (in_last) begin
                        short_d = 1'b1;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + AW'(1);
                    end
                end
            end
            DRAIN: begin
                in_ready = 1'b1;
                if (accept && in_last) state_d = FLUSH;
            end
            FLUSH: state_d = START;
            START: begin
                sort_start = 1'b1;
                lat_d      = '0;
                state_d    = WAIT;
            end
            WAIT: begin
                // Counter lags the cycle count by one; the captured value includes this cycle.
                lat_d = lat_inc;
                if (sort_done) begin
                    cycles_d = lat_inc;
                    done_d   = 1'b1;
                    cnt_d    = '0;
                    state_d  = LOAD;
                end
            end
            default: state_d = LOAD;
        endcase
    end

endmodule

// File: tb/tb_sort_loader.sv
// Randomised scoreboard bench for sort_loader with a frame-level reference model.
module tb_sort_loader;
    localparam int W  = 8;
    localparam int N  = 8;
    localparam int AW = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid, in_last, in_ready;
    logic [W-1:0]  in_data;
    logic          init_mode;
    logic [AW-1:0] init_addr;
    logic [W-1:0]  init_data;
    logic          sort_start, sort_done, frame_done, err_short, err_long;
    logic [CW-1:0] sort_cycles;

    sort_loader #(.W(W), .N_WORDS(N), .AW(AW), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .init_mode(init_mode), .init_addr(init_addr), .init_data(init_data),
        .sort_start(sort_start), .sort_done(sort_done), .frame_done(frame_done),
        .err_short(err_short), .err_long(err_long), .sort_cycles(sort_cycles)
    );

    always #5 clk = ~clk;

    typedef struct { int addr; int data; } wr_t;
    wr_t exp_wr[$];
    int  ram_model [N];
    int  fbuf [16];
    int  n_checks = 0, n_fail = 0;
    int  starts_seen = 0, short_seen = 0, long_seen = 0, done_seen = 0;
    int  exp_starts = 0, exp_short = 0, exp_long = 0, exp_done = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every preload write must match the next expected write in order.
    always @(negedge clk) begin
        if (!reset) begin
            if (init_mode) begin
                if (exp_wr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: addr %0d data %0d, none expected", init_addr, init_data);
                end else begin
                    wr_t w;
                    w = exp_wr.pop_front();
                    chk("wr_addr", init_addr, w.addr);
                    chk("wr_data", init_data, w.data);
                    ram_model[init_addr] = init_data;
                end
            end
            if (sort_start) starts_seen++;
            if (err_short)  short_seen++;
            if (err_long)   long_seen++;
            if (frame_done) done_seen++;
        end
    end

    // Drives fbuf[0..n-1] with in_last on the final word; returns at cycle s if a sort starts.
    task automatic send_frame(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                while ($urandom_range(0, 2) == 0) begin
                    in_valid = 1'b0;
                    in_data  = W'($urandom);
                    in_last  = 1'($urandom);
                    @(negedge clk);
                end
            end
            chk("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_data  = W'(fbuf[i]);
            in_last  = (i == n - 1);
            if (i < N) exp_wr.push_back('{i, fbuf[i]});
            @(negedge clk);
            chk("err_short", err_short, (i == n - 1) && (n < N));
            chk("err_long", err_long, (i == N - 1) && (n > N));
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (n < N) exp_short++;
        if (n > N) exp_long++;
        if (n >= N) begin
            chk("flush_ready", in_ready, 0);
            chk("flush_no_start", sort_start, 0);
            @(negedge clk);
            chk("sort_start", sort_start, 1);
            exp_starts++;
        end else begin
            chk("short_ready", in_ready, 1);
        end
    endtask

    task automatic run_sort(input int len);
        longint exp_cyc;
        exp_cyc = (len > 65535) ? 65535 : len;
        @(negedge clk);
        chk("wait_ready", in_ready, 0);
        chk("start_pulse_width", sort_start, 0);
        repeat (len - 1) @(negedge clk);
        sort_done = 1'b1;
        @(negedge clk);
        sort_done = 1'b0;
        exp_done++;
        chk("frame_done", frame_done, 1);
        chk("sort_cycles", sort_cycles, exp_cyc);
        chk("ready_after_done", in_ready, 1);
        @(negedge clk);
        chk("frame_done_width", frame_done, 0);
    endtask

    task automatic chk_ram(input int n);
        for (int a = 0; a < ((n < N) ? n : N); a++) chk("ram_word", ram_model[a], fbuf[a]);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) fbuf[i] = int'($urandom_range(0, 255));
    endtask

    initial begin
        int n;
        int directed [8] = '{8'h37, 8'h05, 8'hF2, 8'h10, 8'h88, 8'h01, 8'hAA, 8'h3C};
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; sort_done = 1'b0;
        for (int a = 0; a < N; a++) ram_model[a] = -1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_init_mode", init_mode, 0);
        chk("rst_init_addr", init_addr, 0);
        chk("rst_init_data", init_data, 0);
        chk("rst_sort_start", sort_start, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_errs", {err_short, err_long}, 0);
        chk("rst_sort_cycles", sort_cycles, 0);
        reset = 1'b0;
        @(negedge clk);

        // Directed full frame, sort takes 40 cycles.
        for (int i = 0; i < 8; i++) fbuf[i] = directed[i];
        send_frame(8, 1'b0);
        run_sort(40);
        chk_ram(8);

        // Short frame, then a full frame that must restart at address 0.
        fbuf[0] = 8'h11; fbuf[1] = 8'h22; fbuf[2] = 8'h33;
        send_frame(3, 1'b0);
        repeat (3) @(negedge clk);
        chk_ram(3);
        chk("no_start_short", starts_seen, exp_starts);
        fill_random(8);
        send_frame(8, 1'b1);
        run_sort(int'($urandom_range(2, 60)));
        chk_ram(8);

        // Long frame: words 9 and 10 are dropped.
        fill_random(10);
        send_frame(10, 1'b0);
        run_sort(int'($urandom_range(2, 60)));
        chk_ram(8);

        // Reset during WAIT, then a stray sort_done.
        fill_random(8);
        send_frame(8, 1'b0);
        repeat (10) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("arst_in_ready", in_ready, 1);
        chk("arst_init_mode", init_mode, 0);
        chk("arst_sort_cycles", sort_cycles, 0);
        chk("arst_frame_done", frame_done, 0);
        chk("arst_sort_start", sort_start, 0);
        @(negedge clk);
        reset = 1'b0;
        chk("arst_queue_empty", exp_wr.size(), 0);
        sort_done = 1'b1;
        @(negedge clk);
        sort_done = 1'b0;
        chk("stray_done_ignored", frame_done, 0);
        chk("stray_cycles", sort_cycles, 0);
        chk("stray_ready", in_ready, 1);
        fill_random(8);
        send_frame(8, 1'b1);
        run_sort(int'($urandom_range(2, 60)));
        chk_ram(8);

        // Random frame lengths with random gaps.
        for (int f = 0; f < 6; f++) begin
            n = int'($urandom_range(3, 11));
            fill_random(n);
            send_frame(n, 1'b1);
            if (n >= N) run_sort(int'($urandom_range(2, 60)));
            else repeat (2) @(negedge clk);
            chk_ram(n);
        end

        // Saturating latency.
        fill_random(8);
        send_frame(8, 1'b1);
        run_sort(70000);
        chk_ram(8);

        repeat (3) @(negedge clk);
        chk("starts_total", starts_seen, exp_starts);
        chk("short_total", short_seen, exp_short);
        chk("long_total", long_seen, exp_long);
        chk("done_total", done_seen, exp_done);
        chk("writes_left", exp_wr.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
